// File: rtl/la_capture_engine_pkg.sv
// Shared logic-analyzer definitions: capture FSM state encodings
// decoded identically by the engine, host readout and playback.
package la_capture_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE             = 3'd0,
    ST_MOVE_TO_POSITION = 3'd1,
    ST_IN_POSITION      = 3'd2,
    ST_CAPTURING        = 3'd3,
    ST_CAPTURED         = 3'd4
  } la_state_t;

  function automatic logic is_writing(input la_state_t s);
    return (s == ST_MOVE_TO_POSITION) ||
           (s == ST_IN_POSITION) ||
           (s == ST_CAPTURING);
  endfunction

endpackage

// File: rtl/la_capture_engine.sv
// Logic-analyzer capture engine: circular pre-trigger buffering
// into external sample memory, then a fixed post-trigger run.
module la_capture_engine
  import la_capture_engine_pkg::*;
#(
  parameter int SAMPLE_DEPTH      = 4096,
  parameter int TOTAL_PROBE_WIDTH = 7,
  parameter int TRIGGER_LOC       = 0,
  localparam int AW = $clog2(SAMPLE_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [TOTAL_PROBE_WIDTH-1:0] probes,
  input  logic                         trig,
  input  logic                         request_start,
  input  logic                         request_stop,
  output logic [2:0]                   state,
  output logic                         bram_we,
  output logic [AW-1:0]                bram_addr,
  output logic [TOTAL_PROBE_WIDTH-1:0] bram_din,
  output logic [AW-1:0]                read_pointer,
  output logic                         done
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PRE  = CW'(TRIGGER_LOC);
  localparam logic [CW-1:0] POST = CW'(SAMPLE_DEPTH - TRIGGER_LOC);

  la_state_t     st;
  logic [AW-1:0] wp;
  logic [CW-1:0] cnt;
  logic          writing;

  assign writing = is_writing(st);
  assign state   = st;
  assign done    = (st == ST_CAPTURED);

  always_ff @(posedge clk) begin
    if (rst || request_stop) begin
      st           <= ST_IDLE;
      wp           <= '0;
      cnt          <= '0;
      bram_we      <= 1'b0;
      bram_addr    <= '0;
      bram_din     <= '0;
      read_pointer <= '0;
    end else begin
      bram_we <= writing;
      if (writing) begin
        bram_addr <= wp;
        bram_din  <= probes;
        wp        <= wp + AW'(1);
      end
      unique case (st)
        ST_IDLE, ST_CAPTURED: begin
          if (request_start) begin
            st           <= (TRIGGER_LOC == 0) ?
                            ST_IN_POSITION : ST_MOVE_TO_POSITION;
            wp           <= '0;
            cnt          <= '0;
            read_pointer <= '0;
          end
        end
        ST_MOVE_TO_POSITION: begin
          cnt <= cnt + CW'(1);
          if (cnt == PRE - CW'(1)) begin
            st  <= ST_IN_POSITION;
            cnt <= '0;
          end
        end
        ST_IN_POSITION: begin
          if (trig) begin
            cnt <= CW'(1);
            // oldest sample sits right after the last write
            if (POST == CW'(1)) begin
              st           <= ST_CAPTURED;
              read_pointer <= wp + AW'(1);
            end else begin
              st <= ST_CAPTURING;
            end
          end
        end
        ST_CAPTURING: begin
          cnt <= cnt + CW'(1);
          if (cnt == POST - CW'(1)) begin
            st           <= ST_CAPTURED;
            read_pointer <= wp + AW'(1);
            cnt          <= '0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_la_capture_engine.sv
// Directed bench: depth 16 with 4 pre-trigger samples, plus a
// zero pre-trigger build driven by the same stimulus.
module tb_la_capture_engine;

  logic       clk;
  logic       rst;
  logic [6:0] probes;
  logic       trig;
  logic       request_start;
  logic       request_stop;

  logic [2:0] state0, state1;
  logic       we0, we1;
  logic [3:0] addr0, addr1;
  logic [6:0] din0, din1;
  logic [3:0] rptr0, rptr1;
  logic       done0, done1;

  int checks;
  int errors;
  int wcount;
  int wraps;
  logic [3:0] last_addr;

  la_capture_engine #(
    .SAMPLE_DEPTH(16), .TOTAL_PROBE_WIDTH(7), .TRIGGER_LOC(4)
  ) dut0 (
    .clk(clk), .rst(rst), .probes(probes), .trig(trig),
    .request_start(request_start), .request_stop(request_stop),
    .state(state0), .bram_we(we0), .bram_addr(addr0),
    .bram_din(din0), .read_pointer(rptr0), .done(done0)
  );

  la_capture_engine #(
    .SAMPLE_DEPTH(16), .TOTAL_PROBE_WIDTH(7), .TRIGGER_LOC(0)
  ) dut1 (
    .clk(clk), .rst(rst), .probes(probes), .trig(trig),
    .request_start(request_start), .request_stop(request_stop),
    .state(state1), .bram_we(we1), .bram_addr(addr1),
    .bram_din(din1), .read_pointer(rptr1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    logic [6:0] pv;
    for (int i = 0; i < n; i++) begin
      pv = probes;
      @(posedge clk);
      #1;
      if (we0) begin
        wcount++;
        checks++;
        if (din0 !== pv) begin
          errors++;
          $display("FAIL din: got %0d want %0d", din0, pv);
        end
        if (addr0 == 4'd0 && last_addr == 4'd15) wraps++;
        last_addr = addr0;
      end
      probes = probes + 7'd1;
    end
  endtask

  task automatic do_start();
    wcount = 0;
    wraps = 0;
    last_addr = 4'd0;
    request_start = 1'b1;
    step(1);
    request_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({state0, we0, addr0, din0, rptr0, done0} !== 20'd0) begin
      errors++;
      $display("FAIL reset0: got %h want 0",
               {state0, we0, addr0, din0, rptr0, done0});
    end
    checks++;
    if ({state1, we1, addr1, din1, rptr1, done1} !== 20'd0) begin
      errors++;
      $display("FAIL reset1: got %h want 0",
               {state1, we1, addr1, din1, rptr1, done1});
    end
  endtask

  task automatic test_basic();
    do_reset();
    trig = 1'b0;
    do_start();
    checks++;
    if (state0 !== 3'd1 || we0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_start: state %0d we %0b want 1 0",
               state0, we0);
    end
    step(4);
    checks++;
    if (state0 !== 3'd2 || wcount != 4 || addr0 !== 4'd3) begin
      errors++;
      $display("FAIL basic_move: state %0d w %0d addr %0d want 2 4 3",
               state0, wcount, addr0);
    end
    step(5);
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    checks++;
    if (state0 !== 3'd3 || addr0 !== 4'd9) begin
      errors++;
      $display("FAIL basic_trig: state %0d addr %0d want 3 9",
               state0, addr0);
    end
    step(10);
    checks++;
    if (state0 !== 3'd3) begin
      errors++;
      $display("FAIL basic_capturing: state %0d want 3", state0);
    end
    step(1);
    checks++;
    if (state0 !== 3'd4 || done0 !== 1'b1 || wcount != 21 ||
        addr0 !== 4'd4 || rptr0 !== 4'd5) begin
      errors++;
      $display("FAIL basic_done: st %0d d %0b w %0d a %0d rp %0d want 4 1 21 4 5",
               state0, done0, wcount, addr0, rptr0);
    end
    step(3);
    checks++;
    if (state0 !== 3'd4 || we0 !== 1'b0 || rptr0 !== 4'd5 ||
        wcount != 21) begin
      errors++;
      $display("FAIL basic_hold: st %0d we %0b rp %0d w %0d want 4 0 5 21",
               state0, we0, rptr0, wcount);
    end
  endtask

  task automatic test_trig_held();
    do_reset();
    trig = 1'b1;
    do_start();
    step(4);
    checks++;
    if (state0 !== 3'd2) begin
      errors++;
      $display("FAIL held_move: state %0d want 2", state0);
    end
    step(1);
    trig = 1'b0;
    checks++;
    if (state0 !== 3'd3 || addr0 !== 4'd4) begin
      errors++;
      $display("FAIL held_trig: state %0d addr %0d want 3 4",
               state0, addr0);
    end
    step(11);
    checks++;
    if (state0 !== 3'd4 || wcount != 16 || rptr0 !== 4'd0) begin
      errors++;
      $display("FAIL held_done: st %0d w %0d rp %0d want 4 16 0",
               state0, wcount, rptr0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    trig = 1'b0;
    do_start();
    step(20);
    request_start = 1'b1;
    step(1);
    request_start = 1'b0;
    checks++;
    if (state0 !== 3'd2 || addr0 !== 4'd4) begin
      errors++;
      $display("FAIL wrap_ignore_start: state %0d addr %0d want 2 4",
               state0, addr0);
    end
    step(23);
    checks++;
    if (state0 !== 3'd2 || addr0 !== 4'd11 || wraps != 2) begin
      errors++;
      $display("FAIL wrap_inpos: st %0d addr %0d wraps %0d want 2 11 2",
               state0, addr0, wraps);
    end
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    checks++;
    if (state0 !== 3'd3 || addr0 !== 4'd12) begin
      errors++;
      $display("FAIL wrap_trig: state %0d addr %0d want 3 12",
               state0, addr0);
    end
    step(11);
    checks++;
    if (state0 !== 3'd4 || rptr0 !== 4'd8 || wraps != 3) begin
      errors++;
      $display("FAIL wrap_done: st %0d rp %0d wraps %0d want 4 8 3",
               state0, rptr0, wraps);
    end
  endtask

  task automatic test_stop_priority();
    do_reset();
    trig = 1'b0;
    do_start();
    step(4);
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    step(2);
    request_stop = 1'b1;
    request_start = 1'b1;
    step(1);
    request_stop = 1'b0;
    request_start = 1'b0;
    checks++;
    if (state0 !== 3'd0 || we0 !== 1'b0 || addr0 !== 4'd0 ||
        rptr0 !== 4'd0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL stop: st %0d we %0b a %0d rp %0d d %0b want 0",
               state0, we0, addr0, rptr0, done0);
    end
    step(2);
    checks++;
    if (state0 !== 3'd0 || we0 !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: state %0d we %0b want 0 0", state0, we0);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    trig = 1'b0;
    do_start();
    step(4);
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    step(2);
    rst = 1'b1;
    request_start = 1'b1;
    step(1);
    rst = 1'b0;
    request_start = 1'b0;
    checks++;
    if ({state0, we0, addr0, din0, rptr0, done0} !== 20'd0) begin
      errors++;
      $display("FAIL rst_mid: got %h want 0",
               {state0, we0, addr0, din0, rptr0, done0});
    end
    trig = 1'b1;
    do_start();
    step(5);
    trig = 1'b0;
    step(11);
    checks++;
    if (state0 !== 3'd4 || done0 !== 1'b1 || wcount != 16 ||
        rptr0 !== 4'd0) begin
      errors++;
      $display("FAIL rst_recapture: st %0d d %0b w %0d rp %0d want 4 1 16 0",
               state0, done0, wcount, rptr0);
    end
    do_start();
    checks++;
    if (state0 !== 3'd1 || we0 !== 1'b0 || rptr0 !== 4'd0 ||
        done0 !== 1'b0) begin
      errors++;
      $display("FAIL restart: st %0d we %0b rp %0d d %0b want 1 0 0 0",
               state0, we0, rptr0, done0);
    end
  endtask

  task automatic test_loc0();
    do_reset();
    trig = 1'b0;
    do_start();
    checks++;
    if (state1 !== 3'd2 || we1 !== 1'b0) begin
      errors++;
      $display("FAIL loc0_start: state %0d we %0b want 2 0", state1, we1);
    end
    step(3);
    checks++;
    if (we1 !== 1'b1 || addr1 !== 4'd2) begin
      errors++;
      $display("FAIL loc0_pre: we %0b addr %0d want 1 2", we1, addr1);
    end
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    checks++;
    if (state1 !== 3'd3 || addr1 !== 4'd3) begin
      errors++;
      $display("FAIL loc0_trig: state %0d addr %0d want 3 3",
               state1, addr1);
    end
    step(14);
    checks++;
    if (state1 !== 3'd3) begin
      errors++;
      $display("FAIL loc0_capturing: state %0d want 3", state1);
    end
    step(1);
    checks++;
    if (state1 !== 3'd4 || done1 !== 1'b1 || rptr1 !== 4'd3) begin
      errors++;
      $display("FAIL loc0_done: st %0d d %0b rp %0d want 4 1 3",
               state1, done1, rptr1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wcount = 0;
    wraps = 0;
    last_addr = 4'd0;
    rst = 1'b1;
    probes = 7'd0;
    trig = 1'b0;
    request_start = 1'b0;
    request_stop = 1'b0;
    test_reset();
    test_basic();
    test_trig_held();
    test_wrap();
    test_stop_priority();
    test_rst_mid();
    test_loc0();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
